// File: rtl/country_sensor_conditioner.sv
// Country-road loop detector conditioner: synchronizes and debounces the raw sensor,
// queues vehicles, and produces the controller's x request with green-limit and highway hold-off.
module country_sensor_conditioner #(
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 4,
    parameter int PASS_CYCLES = 3,
    parameter int MAX_GREEN   = 16,
    parameter int MIN_HWY     = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             sensor_raw,
    input  logic [1:0]       cntry,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow,
    output logic [2:0]       fsm_state
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(PASS_CYCLES + 1);
    localparam int GW = $clog2(MAX_GREEN + 1);
    localparam int HW = $clog2(MIN_HWY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [1:0]       LAMP_RED   = 2'd0;
    localparam logic [1:0]       LAMP_GREEN = 2'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        SERVE   = 3'd2,
        RELEASE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t           state_reg;
    logic             s1_reg, s2_reg, filt_reg, filt_prev_reg;
    logic [DW-1:0]    deb_cnt_reg;
    logic [PW-1:0]    pass_tmr_reg;
    logic [GW-1:0]    green_tmr_reg;
    logic [HW-1:0]    hold_tmr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg;
    logic             arrival, departure, lost;

    // Two-flop synchronizer followed by a stability filter on the synchronized level.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1_reg        <= 1'b0;
            s2_reg        <= 1'b0;
            filt_reg      <= 1'b0;
            filt_prev_reg <= 1'b0;
            deb_cnt_reg   <= '0;
        end else begin
            s1_reg        <= sensor_raw;
            s2_reg        <= s1_reg;
            filt_prev_reg <= filt_reg;
            if (s2_reg == filt_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DW'(DEBOUNCE - 1)) begin
                filt_reg    <= s2_reg;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    assign arrival   = filt_reg & ~filt_prev_reg;
    assign departure = (state_reg == SERVE) && (pass_tmr_reg == PW'(PASS_CYCLES - 1));

    // A simultaneous arrival and departure cancel, so no arrival is lost even when full.
    always_comb begin
        count_next = count_reg;
        lost       = 1'b0;
        if (arrival && !departure) begin
            if (count_reg == CNT_MAX) lost = 1'b1;
            else                      count_next = count_reg + 1'b1;
        end else if (departure && !arrival && count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (lost) overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg     <= IDLE;
            pass_tmr_reg  <= '0;
            green_tmr_reg <= '0;
            hold_tmr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arrival) state_reg <= REQ;
                end
                REQ: begin
                    if (cntry == LAMP_GREEN) begin
                        state_reg     <= SERVE;
                        pass_tmr_reg  <= '0;
                        green_tmr_reg <= '0;
                    end
                end
                SERVE: begin
                    green_tmr_reg <= green_tmr_reg + 1'b1;
                    pass_tmr_reg  <= departure ? '0 : pass_tmr_reg + 1'b1;
                    if (count_next == '0 || green_tmr_reg == GW'(MAX_GREEN - 1) ||
                        cntry != LAMP_GREEN)
                        state_reg <= RELEASE;
                end
                RELEASE: begin
                    if (cntry == LAMP_RED) begin
                        state_reg    <= HOLD;
                        hold_tmr_reg <= '0;
                    end
                end
                HOLD: begin
                    // count_next so an arrival landing on this edge is not stranded in IDLE
                    if (hold_tmr_reg == HW'(MIN_HWY - 1))
                        state_reg <= (count_next != '0) ? REQ : IDLE;
                    else
                        hold_tmr_reg <= hold_tmr_reg + 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign x         = (state_reg == REQ) || (state_reg == SERVE);
    assign car_count = count_reg;
    assign overflow  = overflow_reg;
    assign fsm_state = state_reg;

endmodule

// File: tb/tb_country_sensor_conditioner.sv
// Directed and randomized checks of the country sensor conditioner against a
// queue-arithmetic model of arrivals, departures and service windows.
module tb_country_sensor_conditioner;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       sensor_raw;
    logic [1:0] cntry;
    logic       x;
    logic [3:0] car_count;
    logic       overflow;
    logic [2:0] fsm_state;

    int total = 0;
    int bad   = 0;

    country_sensor_conditioner dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .cntry      (cntry),
        .x          (x),
        .car_count  (car_count),
        .overflow   (overflow),
        .fsm_state  (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Clean vehicle: 7 high samples then a long low gap so the filter settles back to 0.
    task automatic add_car();
        sensor_raw = 1'b1;
        repeat (7) tick();
        sensor_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int mcount, deps, last_edge, len, g;
        bit movf, valid;

        clear_n    = 1'b1;
        sensor_raw = 1'b0;
        cntry      = 2'd0;
        #2 clear_n = 1'b0;
        #1;
        check("por_x", 32'(x), 0);
        check("por_count", 32'(car_count), 0);
        check("por_ovf", 32'(overflow), 0);
        check("por_state", 32'(fsm_state), 0);
        @(posedge clock);
        #1 clear_n = 1'b1;

        // Short glitches are ignored
        repeat (2) begin
            sensor_raw = 1'b1;
            repeat (3) tick();
            sensor_raw = 1'b0;
            repeat (8) tick();
        end
        check("glitch_count", 32'(car_count), 0);
        check("glitch_state", 32'(fsm_state), 0);
        $display("glitch pulses done count=%0d", car_count);

        // 10-cycle pulse: count lands 6 edges after the first high sample
        sensor_raw = 1'b1;
        repeat (6) tick();
        check("deb_early_count", 32'(car_count), 0);
        check("deb_early_x", 32'(x), 0);
        tick();
        check("deb_count", 32'(car_count), 1);
        check("deb_x", 32'(x), 1);
        check("deb_state", 32'(fsm_state), 1);
        repeat (3) tick();
        sensor_raw = 1'b0;
        repeat (8) tick();
        check("deb_single", 32'(car_count), 1);
        $display("debounce pulse done count=%0d", car_count);

        // Normal service of two cars
        add_car();
        check("svc_queued", 32'(car_count), 2);
        cntry = 2'd2;
        tick();
        check("svc_state", 32'(fsm_state), 2);
        repeat (2) tick();
        check("svc_c2", 32'(car_count), 2);
        tick();
        check("svc_c1", 32'(car_count), 1);
        repeat (2) tick();
        check("svc_x_hi", 32'(x), 1);
        tick();
        check("svc_c0", 32'(car_count), 0);
        check("svc_x_lo", 32'(x), 0);
        check("svc_rel", 32'(fsm_state), 3);
        cntry = 2'd1;
        repeat (2) tick();
        check("svc_rel_wait", 32'(fsm_state), 3);
        cntry = 2'd0;
        tick();
        check("svc_hold", 32'(fsm_state), 4);
        repeat (7) tick();
        check("svc_hold_end", 32'(fsm_state), 4);
        tick();
        check("svc_idle", 32'(fsm_state), 0);
        $display("normal service done state=%0d", fsm_state);

        // Green limit with ten cars
        repeat (10) add_car();
        check("gl_queued", 32'(car_count), 10);
        check("gl_req", 32'(fsm_state), 1);
        cntry = 2'd2;
        tick();
        repeat (15) tick();
        check("gl_serve15", 32'(fsm_state), 2);
        check("gl_count15", 32'(car_count), 5);
        tick();
        check("gl_rel", 32'(fsm_state), 3);
        check("gl_x", 32'(x), 0);
        check("gl_count", 32'(car_count), 5);
        cntry = 2'd0;
        tick();
        check("gl_hold", 32'(fsm_state), 4);
        repeat (7) tick();
        check("gl_hold_end", 32'(x), 0);
        tick();
        check("gl_req_again", 32'(fsm_state), 1);
        check("gl_x_again", 32'(x), 1);
        $display("green limit done count=%0d", car_count);

        // Arrival coinciding with a departure at count 3
        cntry = 2'd2;
        tick();
        repeat (2) tick();
        sensor_raw = 1'b1;
        tick();
        check("sim_c4", 32'(car_count), 4);
        repeat (3) tick();
        check("sim_c3", 32'(car_count), 3);
        repeat (2) tick();
        sensor_raw = 1'b0;
        tick();
        check("sim_hold3", 32'(car_count), 3);
        check("sim_serve", 32'(fsm_state), 2);
        repeat (3) tick();
        check("sim_c2", 32'(car_count), 2);
        cntry = 2'd0;
        tick();
        check("sim_rel", 32'(fsm_state), 3);
        tick();
        repeat (8) tick();
        check("sim_req", 32'(fsm_state), 1);
        $display("simultaneous event done count=%0d", car_count);

        // Saturation
        repeat (13) add_car();
        check("sat_15", 32'(car_count), 15);
        check("sat_no_ovf", 32'(overflow), 0);
        add_car();
        check("sat_hold", 32'(car_count), 15);
        check("sat_ovf", 32'(overflow), 1);
        cntry = 2'd2;
        tick();
        repeat (3) tick();
        check("sat_dep", 32'(car_count), 14);
        check("sat_ovf_sticky", 32'(overflow), 1);
        $display("saturation done count=%0d ovf=%0d", car_count, overflow);

        // Asynchronous reset while serving a queue
        clear_n = 1'b0;
        #1;
        check("rst_x", 32'(x), 0);
        check("rst_count", 32'(car_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_state", 32'(fsm_state), 0);
        cntry = 2'd0;
        @(posedge clock);
        #1 clear_n = 1'b1;

        // Randomized rounds of pulses and service windows
        mcount = 0;
        movf   = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 6; p++) begin
                valid = ($urandom_range(0, 2) != 0);
                len   = valid ? $urandom_range(4, 9) : $urandom_range(1, 3);
                sensor_raw = 1'b1;
                repeat (len) tick();
                sensor_raw = 1'b0;
                repeat (10) tick();
                if (valid) begin
                    if (mcount == 15) movf = 1'b1;
                    else              mcount++;
                end
                $display("pulse r=%0d p=%0d len=%0d count=%0d model=%0d", r, p, len, car_count, mcount);
                check("rnd_count", 32'(car_count), 32'(mcount));
                check("rnd_ovf", 32'(overflow), 32'(movf));
                check("rnd_state", 32'(fsm_state), (mcount > 0) ? 1 : 0);
            end
            if (mcount > 0) begin
                g = $urandom_range(1, 18);
                cntry = 2'd2;
                tick();
                repeat (g) tick();
                cntry = 2'd0;
                repeat (12) tick();
                last_edge = (g + 1 < 16) ? g + 1 : 16;
                deps = last_edge / 3;
                if (deps > mcount) deps = mcount;
                mcount -= deps;
                $display("service r=%0d green=%0d count=%0d model=%0d", r, g, car_count, mcount);
                check("svc_rnd_count", 32'(car_count), 32'(mcount));
                check("svc_rnd_state", 32'(fsm_state), (mcount > 0) ? 1 : 0);
                check("svc_rnd_ovf", 32'(overflow), 32'(movf));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
